rom_spi_reader: RTL and testbench

- Responder on the ROM side of the ROM-to-RAM init copy interface.
- Serves byte read requests (rom_address/rom_rden) by issuing SPI READ (0x03) transactions to the on-board serial flash. Returns each byte on rom_data with a one-cycle rom_data_ready strobe.
- Keeps chip select asserted between requests so that consecutive addresses stream without resending command and address.

---
 rtl/rom_spi_pkg.sv | 26 ++
 rtl/spi_bit_engine.sv | 76 +++++++
 rtl/rom_spi_reader.sv | 150 +++++++++++++++
 tb/tb_rom_spi_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_spi_pkg
// Description : Shared types and constants for the ROM-side SPI flash reader.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DESEL = 3'd1,
        CMD   = 3'd2,
        ADDR  = 3'd3,
        DATA  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 8;
    localparam int HDR_BITS  = CMD_BITS + ADDR_BITS;

endpackage
`default_nettype wire

// File: rtl/spi_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_engine
// Description : Mode-0 SPI shifter, up to 32 bits per start, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        bit_end,
    output logic        done,
    output logic [5:0]  bits_left,
    output logic [7:0]  rx_byte
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [31:0]      shreg;
    logic             rx_bit;
    logic             tick;

    assign tick    = active && (div_cnt == DIV_LAST);
    assign bit_end = tick && sck;
    assign done    = bit_end && (bits_left == 6'd1);
    assign mosi    = active && shreg[31];
    // Byte as it will look after the closing shift, so done can hand it over.
    assign rx_byte = {shreg[6:0], rx_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            div_cnt   <= '0;
            sck       <= 1'b0;
            shreg     <= '0;
            rx_bit    <= 1'b0;
            bits_left <= '0;
        end else if (start) begin
            active    <= 1'b1;
            div_cnt   <= '0;
            sck       <= 1'b0;
            shreg     <= tx_data;
            bits_left <= nbits;
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                if (!sck) begin
                    sck    <= 1'b1;
                    rx_bit <= miso;
                end else begin
                    // MOSI only moves on the falling edge to keep hold time at the flash.
                    sck       <= 1'b0;
                    shreg     <= {shreg[30:0], rx_bit};
                    bits_left <= bits_left - 6'd1;
                    if (bits_left == 6'd1) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_spi_reader
// Description : Serves byte reads from SPI flash, streaming sequential bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_spi_reader
    import rom_spi_pkg::*;
#(
    parameter int          ADDR_W     = 17,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLK_DIV    = 2,
    parameter int          CS_HIGH    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_address,
    input  logic              rom_rden,
    output logic [7:0]        rom_data,
    output logic              rom_data_ready,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int DESEL_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
    localparam logic [DESEL_W-1:0] DESEL_LAST = DESEL_W'(CS_HIGH - 1);
    localparam logic [ADDR_W:0]    ADDR_ONE   = (ADDR_W + 1)'(1);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   req_address, last_address;
    logic                stream_valid;
    logic [DESEL_W-1:0]  desel_cnt;
    logic                accept, seq_hit;

    logic                eng_start, eng_bit_end, eng_done;
    logic [5:0]          eng_nbits, eng_bits_left;
    logic [31:0]         eng_tx;
    logic [7:0]          eng_rx_byte;

    function automatic logic [23:0] flash_addr(input logic [ADDR_W-1:0] a);
        return FLASH_BASE + 24'(a);
    endfunction

    // Busy covers the ready cycle so a strobe coinciding with ready is dropped.
    assign busy     = ((state != IDLE) && (state != HOLD)) || rom_data_ready;
    assign accept   = rom_rden && !busy;
    assign seq_hit  = stream_valid && ({1'b0, rom_address} == ({1'b0, last_address} + ADDR_ONE));
    assign spi_cs_n = (state == IDLE) || (state == DESEL);

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (clock),
        .rst       (reset),
        .start     (eng_start),
        .nbits     (eng_nbits),
        .tx_data   (eng_tx),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .bit_end   (eng_bit_end),
        .done      (eng_done),
        .bits_left (eng_bits_left),
        .rx_byte   (eng_rx_byte)
    );

    always_comb begin
        state_next = state;
        eng_start  = 1'b0;
        eng_nbits  = 6'(HDR_BITS);
        eng_tx     = {SPI_CMD_READ, flash_addr(req_address)};
        case (state)
            IDLE: begin
                if (accept) begin
                    eng_start  = 1'b1;
                    eng_tx     = {SPI_CMD_READ, flash_addr(rom_address)};
                    state_next = CMD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (seq_hit) begin
                        eng_start  = 1'b1;
                        eng_nbits  = 6'(DATA_BITS);
                        eng_tx     = '0;
                        state_next = DATA;
                    end else begin
                        state_next = DESEL;
                    end
                end
            end
            DESEL: begin
                if (desel_cnt == DESEL_LAST) begin
                    eng_start  = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (eng_bit_end && (eng_bits_left == 6'(ADDR_BITS + 1))) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                // Chain straight into the data byte so no SCK gap appears.
                if (eng_done) begin
                    eng_start  = 1'b1;
                    eng_nbits  = 6'(DATA_BITS);
                    eng_tx     = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (eng_done) begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            req_address    <= '0;
            last_address   <= '0;
            stream_valid   <= 1'b0;
            desel_cnt      <= '0;
            rom_data       <= '0;
            rom_data_ready <= 1'b0;
        end else begin
            state          <= state_next;
            rom_data_ready <= 1'b0;
            if (accept) begin
                req_address <= rom_address;
            end
            desel_cnt <= (state == DESEL) ? desel_cnt + DESEL_W'(1) : '0;
            if ((state == DATA) && eng_done) begin
                rom_data       <= eng_rx_byte;
                rom_data_ready <= 1'b1;
                last_address   <= req_address;
                stream_valid   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_spi_reader
// Description : Bench with flash model and request-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_spi_reader;

    localparam int          ADDR_W     = 17;
    localparam logic [23:0] FLASH_BASE = 24'h080000;
    localparam int          CLK_DIV    = 2;
    localparam int          CS_HIGH    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_address;
    logic              rom_rden;
    logic [7:0]        rom_data;
    logic              rom_data_ready;
    logic              busy;
    logic              spi_sck, spi_cs_n, spi_mosi;
    logic              spi_miso;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rom_spi_reader #(
        .ADDR_W     (ADDR_W),
        .FLASH_BASE (FLASH_BASE),
        .CLK_DIV    (CLK_DIV),
        .CS_HIGH    (CS_HIGH)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .rom_address    (rom_address),
        .rom_rden       (rom_rden),
        .rom_data       (rom_data),
        .rom_data_ready (rom_data_ready),
        .busy           (busy),
        .spi_sck        (spi_sck),
        .spi_cs_n       (spi_cs_n),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h42;
    endfunction

    // ---------------- serial flash model ----------------
    int          fbits = 0;
    logic [31:0] fhdr  = '0;
    logic [31:0] first_hdr = '0;
    int          hdr_count = 0;
    logic [31:0] got_hdr[$];

    always @(posedge spi_cs_n) fbits = 0;

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            if (fbits < 32) fhdr = {fhdr[30:0], spi_mosi};
            fbits++;
            if (fbits == 32) begin
                got_hdr.push_back(fhdr);
                if (hdr_count == 0) first_hdr = fhdr;
                hdr_count++;
            end
        end
    end

    always_comb begin
        logic [7:0] fb;
        int         k;
        fb = 8'h00;
        k  = 0;
        spi_miso = 1'b0;
        if (fbits >= 32) begin
            k  = fbits - 32;
            fb = flash_byte(fhdr[23:0] + 24'(k / 8));
            spi_miso = fb[7 - (k % 8)];
        end
    end

    // ---------------- request-level reference model ----------------
    logic              m_live = 1'b0;
    logic              m_pend = 1'b0;
    logic              m_open = 1'b0;
    logic              m_sv   = 1'b0;
    logic              m_desel = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0, m_last = '0;
    logic [7:0]        m_data = '0, m_last_data = '0;
    int                m_acc = 0, m_rdy = 0;
    logic [31:0]       exp_hdr[$];

    always @(negedge clk) begin
        logic exp_ready, was_pend, hit;
        int   lat;
        exp_ready = m_pend && (cyc == m_rdy);
        was_pend  = m_pend;
        if (m_live) begin
            chk("ready", 32'(rom_data_ready), 32'(exp_ready));
            if (exp_ready) begin
                chk("data", 32'(rom_data), 32'(m_data));
                chk("hdr_count", 32'(got_hdr.size()), 32'(exp_hdr.size()));
                while (got_hdr.size() > 0 && exp_hdr.size() > 0)
                    chk("hdr", got_hdr.pop_front(), exp_hdr.pop_front());
            end else begin
                chk("data_hold", 32'(rom_data), 32'(m_last_data));
                chk("busy", 32'(busy), 32'(m_pend));
            end
            if (m_pend)
                chk("cs_n", 32'(spi_cs_n), 32'(m_desel && (cyc <= m_acc + CS_HIGH)));
            else begin
                chk("cs_n_rest", 32'(spi_cs_n), 32'(!m_open));
                chk("sck_rest", 32'(spi_sck), 32'd0);
                chk("mosi_rest", 32'(spi_mosi), 32'd0);
            end
        end
        if (exp_ready) begin
            m_pend = 1'b0; m_open = 1'b1; m_sv = 1'b1;
            m_last = m_addr; m_last_data = m_data;
        end
        if (reset) begin
            m_live = 1'b1; m_pend = 1'b0; m_open = 1'b0; m_sv = 1'b0;
            m_last_data = 8'h00;
            exp_hdr.delete();
            got_hdr.delete();
        end else if (m_live && rom_rden && !was_pend) begin
            hit = m_open && m_sv && (m_last != '1) && (rom_address == m_last + 1'b1);
            // Every bit costs two SCK half-periods; one extra cycle to launch.
            if (hit) lat = 1 + 2 * CLK_DIV * 8;
            else     lat = 1 + 2 * CLK_DIV * (8 + 24 + 8) + (m_open ? CS_HIGH : 0);
            if (!hit) exp_hdr.push_back({8'h03, FLASH_BASE + 24'(rom_address)});
            m_desel = m_open && !hit;
            m_addr  = rom_address;
            m_data  = flash_byte(FLASH_BASE + 24'(rom_address));
            m_acc   = cyc;
            m_rdy   = cyc + lat;
            m_pend  = 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic do_read(input logic [ADDR_W-1:0] a, input int spur_at, input int rst_at,
                           output int lat, output int cs_hi, output logic [7:0] d);
        lat = 0; cs_hi = 0; d = 8'h00;
        @(posedge clk); #1;
        rom_rden = 1'b1; rom_address = a;
        forever begin
            @(posedge clk); #1;
            rom_rden = 1'b0; reset = 1'b0;
            lat++;
            if (lat == spur_at) begin rom_rden = 1'b1; rom_address = '0; end
            if (lat == rst_at) reset = 1'b1;
            @(negedge clk);
            if (spi_cs_n) cs_hi++;
            if (rst_at > 0 && lat == rst_at + 1) break;
            if (rom_data_ready) begin d = rom_data; break; end
            if (lat > 400) begin
                chk("ready_timeout", 32'(lat), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                lat, cs_hi;
        logic [7:0]        d;
        logic [ADDR_W-1:0] a, last;
        reset = 1'b1; rom_rden = 1'b0; rom_address = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(rom_data), 32'd0);

        // Random read from idle
        do_read(17'h00010, 0, 0, lat, cs_hi, d);
        chk("idle_lat", 32'(lat), 32'd161);
        chk("idle_byte", 32'(d), 32'h5A);
        chk("idle_hdr", first_hdr, 32'h03080010);
        repeat (3) @(negedge clk);
        chk("hold_cs_low", 32'(spi_cs_n), 32'd0);

        // Sequential hit, then a strobe coinciding with ready
        do_read(17'h00011, 0, 0, lat, cs_hi, d);
        chk("seq_lat", 32'(lat), 32'd33);
        chk("seq_byte", 32'(d), 32'h5B);
        chk("seq_no_desel", 32'(cs_hi), 32'd0);
        chk("seq_no_hdr", 32'(hdr_count), 32'd1);
        rom_rden = 1'b1; rom_address = 17'h00012;
        @(posedge clk); #1 rom_rden = 1'b0;
        repeat (40) @(negedge clk);

        // Miss from hold
        do_read(17'h00100, 0, 0, lat, cs_hi, d);
        chk("miss_lat", 32'(lat), 32'd165);
        chk("miss_desel", 32'(cs_hi), 32'd4);
        chk("miss_byte", 32'(d), 32'h4B);
        chk("miss_hdr_count", 32'(hdr_count), 32'd2);

        // Spurious strobe during DATA
        do_read(17'h00010, 150, 0, lat, cs_hi, d);
        chk("spur_lat", 32'(lat), 32'd165);
        chk("spur_byte", 32'(d), 32'h5A);

        // Reset during ADDR
        do_read(17'h00500, 0, 70, lat, cs_hi, d);
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sck", 32'(spi_sck), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(rom_data_ready), 32'd0);
        do_read(17'h00011, 0, 0, lat, cs_hi, d);
        chk("post_abort_lat", 32'(lat), 32'd161);
        chk("post_abort_byte", 32'(d), 32'h5B);

        // Address wrap
        do_read(17'h1FFFE, 0, 0, lat, cs_hi, d);
        chk("wrap0_byte", 32'(d), 32'h4A);
        do_read(17'h1FFFF, 0, 0, lat, cs_hi, d);
        chk("wrap1_lat", 32'(lat), 32'd33);
        chk("wrap1_byte", 32'(d), 32'h4B);
        do_read(17'h00000, 0, 0, lat, cs_hi, d);
        chk("wrap2_lat", 32'(lat), 32'd165);
        chk("wrap2_desel", 32'(cs_hi), 32'd4);
        chk("wrap2_byte", 32'(d), 32'h4A);

        // Randomized mix of hits, misses and ignored strobes
        last = 17'h00000;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) a = last + 1'b1;
            else                           a = ADDR_W'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_read(a, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0, 0, lat, cs_hi, d);
            last = a;
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
